// File: rtl/march_bist.sv
// march_bist: March C- built-in self-test controller for one single-port
// synchronous RAM (read data returned one cycle after mem_re).
//
// Sequence: M0 up(w D0), M1 up(r D0,w D1), M2 up(r D1,w D0),
//           M3 down(r D0,w D1), M4 down(r D1,w D0), M5 down(r D0),
//           then one DRAIN cycle for the final compare, then DONE.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begin a test (accepted in IDLE or DONE only)
//   mem_addr/wdata   registered RAM address / write data
//   mem_we/mem_re    registered RAM write / read enables
//   mem_rdata        RAM read data, valid the cycle after mem_re
//   busy             op cycles through the drain cycle
//   done, pass       test complete / no mismatches seen
//   err_count        saturating mismatch count
//   fail_addr/data   address and read data of the first mismatch
module march_bist #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  function automatic logic [DATA_W-1:0] pat_d0();
    logic [DATA_W-1:0] p;
    for (int unsigned i = 0; i < DATA_W; i++) p[i] = ((i % 2) == 0);
    return p;
  endfunction

  localparam logic [DATA_W-1:0] D0       = pat_d0();
  localparam logic [DATA_W-1:0] D1       = ~D0;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              phase, phase_n;   // 0: read half, 1: write half
  logic              we_n, re_n;
  logic [DATA_W-1:0] wdata_n, exp_n;

  // Expected data travels with the read op, then one more stage to line
  // up with mem_rdata.
  logic [DATA_W-1:0] rd_exp;
  logic              cmp_valid;
  logic [DATA_W-1:0] cmp_data;
  logic [ADDR_W-1:0] cmp_addr;
  logic              mismatch;
  logic              start_hit;

  assign mem_addr  = addr;
  assign mismatch  = cmp_valid && (mem_rdata != cmp_data);
  assign start_hit = start && ((state == IDLE) || (state == DONE));

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      phase     <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      rd_exp    <= '0;
      cmp_valid <= 1'b0;
      cmp_data  <= '0;
      cmp_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      phase     <= phase_n;
      mem_we    <= we_n;
      mem_re    <= re_n;
      mem_wdata <= wdata_n;
      rd_exp    <= exp_n;
      cmp_valid <= mem_re;
      cmp_data  <= rd_exp;
      cmp_addr  <= addr;
      busy      <= (state_n != IDLE) && (state_n != DONE);
      done      <= (state_n == DONE);
      if (start_hit) begin
        pass      <= 1'b0;
        err_count <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_addr <= cmp_addr;
          fail_data <= mem_rdata;
        end
      end
      // The last M5 read is still being compared during DRAIN, so fold it in.
      if (state == DRAIN) pass <= (err_count == '0) && !mismatch;
    end
  end

  // Next-state / address sequencing
  always_comb begin
    state_n = state;
    addr_n  = addr;
    phase_n = phase;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = M0;
          addr_n  = '0;
          phase_n = 1'b0;
        end
      end
      M0: begin
        if (addr == ADDR_MAX) begin
          state_n = M1;
          addr_n  = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      M1, M2: begin
        phase_n = ~phase;
        if (phase) begin
          if (addr == ADDR_MAX) begin
            state_n = (state == M1) ? M2 : M3;
            addr_n  = (state == M1) ? '0 : ADDR_MAX;
          end else begin
            addr_n = addr + 1'b1;
          end
        end
      end
      M3, M4: begin
        phase_n = ~phase;
        if (phase) begin
          if (addr == '0) begin
            state_n = (state == M3) ? M4 : M5;
            addr_n  = ADDR_MAX;
          end else begin
            addr_n = addr - 1'b1;
          end
        end
      end
      M5: begin
        if (addr == '0) state_n = DRAIN;
        else            addr_n  = addr - 1'b1;
      end
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Op decode for the cycle being entered (registered onto mem_* above)
  always_comb begin
    we_n    = 1'b0;
    re_n    = 1'b0;
    wdata_n = '0;
    exp_n   = '0;
    unique case (state_n)
      M0: begin we_n = 1'b1; wdata_n = D0; end
      M1: if (phase_n) begin we_n = 1'b1; wdata_n = D1; end
          else         begin re_n = 1'b1; exp_n   = D0; end
      M2: if (phase_n) begin we_n = 1'b1; wdata_n = D0; end
          else         begin re_n = 1'b1; exp_n   = D1; end
      M3: if (phase_n) begin we_n = 1'b1; wdata_n = D1; end
          else         begin re_n = 1'b1; exp_n   = D0; end
      M4: if (phase_n) begin we_n = 1'b1; wdata_n = D0; end
          else         begin re_n = 1'b1; exp_n   = D1; end
      M5: begin re_n = 1'b1; exp_n = D0; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_march_bist.sv
module tb_march_bist;

  typedef struct {
    int          lat;
    bit          pass;
    int          err;
    bit          err_gt0;   // only require a nonzero count
    logic [3:0]  fa;
    logic [7:0]  fd;
    int          start_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mem_addr, mem_addr2;
  logic [7:0] mem_wdata, mem_wdata2;
  logic       mem_we, mem_re, mem_we2, mem_re2;
  logic [7:0] mem_rdata = '0, mem_rdata2 = '0;
  logic       busy, done, pass, busy2, done2, pass2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic [3:0] fail_addr, fail_addr2;
  logic [7:0] fail_data, fail_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rcnt = 0, wcnt = 0;
  int fault = 0;          // 0 none, 1 bit0 stuck-0 at addr 5, 2 addr bit3 ignored
  exp_t q1[$];
  exp_t q2[$];
  logic [7:0] ram [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  march_bist #(.ADDR_W(4), .DATA_W(8), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // Second instance: narrow counter, RAM that always reads 0x00
  march_bist #(.ADDR_W(4), .DATA_W(8), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_re(mem_re2),
    .mem_rdata(mem_rdata2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .fail_addr(fail_addr2), .fail_data(fail_data2)
  );

  function automatic logic [3:0] ram_idx(input logic [3:0] a);
    return (fault == 2) ? {1'b0, a[2:0]} : a;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[ram_idx(mem_addr)] <= mem_wdata;
      wcnt <= wcnt + 1;
    end
    if (mem_re) begin
      rcnt <= rcnt + 1;
      if (fault == 1 && mem_addr == 4'd5) mem_rdata <= ram[ram_idx(mem_addr)] & 8'hFE;
      else                                mem_rdata <= ram[ram_idx(mem_addr)];
    end
    if (mem_re2) mem_rdata2 <= 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitors: compare on each rising edge of done
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (q1.size() == 0) check("dut_unexpected_done", 1, 0);
        else begin
          e = q1.pop_front();
          check("dut_latency", cyc - e.start_cyc, e.lat);
          check("dut_pass", pass, e.pass);
          if (e.err_gt0) check("dut_err_nonzero", err_count != 0, 1);
          else           check("dut_err_count", err_count, e.err);
          check("dut_fail_addr", fail_addr, e.fa);
          check("dut_fail_data", fail_data, e.fd);
          check("dut_reads", rcnt, 80);
          check("dut_writes", wcnt, 80);
          check("dut_busy_low_in_done", busy, 0);
        end
      end
      prev = done;
    end
  end

  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2 && !prev) begin
        if (q2.size() == 0) check("dut2_unexpected_done", 1, 0);
        else begin
          e = q2.pop_front();
          check("dut2_latency", cyc - e.start_cyc, e.lat);
          check("dut2_pass", pass2, e.pass);
          check("dut2_err_sat", err_count2, e.err);
          check("dut2_fail_addr", fail_addr2, e.fa);
          check("dut2_fail_data", fail_data2, e.fd);
        end
      end
      prev = done2;
    end
  end

  // Pulse start for one edge; optionally push expectations for both DUTs.
  task automatic do_start(input bit push, input bit e_pass, input int e_err,
                          input bit e_gt0, input logic [3:0] e_fa, input logic [7:0] e_fd);
    exp_t e, e2;
    @(negedge clk);
    rcnt = 0;
    wcnt = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e = '{lat: 161, pass: e_pass, err: e_err, err_gt0: e_gt0, fa: e_fa, fd: e_fd, start_cyc: cyc};
      e2 = '{lat: 161, pass: 1'b0, err: 3, err_gt0: 1'b0, fa: 4'h0, fd: 8'h00, start_cyc: cyc};
      q1.push_back(e);
      q2.push_back(e2);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fault-free run, first op checked directly
    fault = 0;
    do_start(1, 1, 0, 0, 4'h0, 8'h00);
    check("first_op_we", mem_we, 1);
    check("first_op_re", mem_re, 0);
    check("first_op_addr", mem_addr, 0);
    check("first_op_wdata", mem_wdata, 8'h55);
    check("first_op_busy", busy, 1);
    wait_done();

    // bit0 stuck-at-0 at address 5: D0 reads in M1, M3, M5 fail
    fault = 1;
    do_start(1, 0, 3, 0, 4'h5, 8'h54);
    wait_done();

    // Restart from DONE clears status
    fault = 0;
    do_start(1, 1, 0, 0, 4'h0, 8'h00);
    check("restart_done_cleared", done, 0);
    check("restart_pass_cleared", pass, 0);
    check("restart_err_cleared", err_count, 0);
    check("restart_fail_addr_cleared", fail_addr, 0);
    check("restart_fail_data_cleared", fail_data, 0);
    wait_done();

    // Address alias: cell 8 reads cell 0, which M1 already rewrote to D1
    fault = 2;
    do_start(1, 0, 0, 1, 4'h8, 8'hAA);
    wait_done();

    // Extra start during M2 must be ignored
    fault = 0;
    do_start(1, 1, 0, 0, 4'h0, 8'h00);
    repeat (59) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-run at op cycle 50 (after an error has been counted)
    fault = 1;
    do_start(0, 0, 0, 0, 4'h0, 8'h00);
    repeat (48) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_we", mem_we, 0);
    check("midrst_re", mem_re, 0);
    check("midrst_err", err_count, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    fault = 0;
    do_start(1, 1, 0, 0, 4'h0, 8'h00);
    wait_done();

    check("dut_queue_empty", q1.size(), 0);
    check("dut2_queue_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
